// File: rtl/enemy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_pkg
//  Description : Shared types and constants for the enemy swarm: FSM state
//                enum, sprite size defaults (shared with the enemy bitmap),
//                slot-index/coordinate types and a saturating adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package enemy_pkg;

    // Sprite geometry, also used by the enemy bitmap ROM
    localparam int OBJECT_WIDTH_X  = 11;
    localparam int OBJECT_HEIGHT_Y = 48;

    // Default slot count and the matching slot-index width
    localparam int NUM_ENEMIES_DEF = 4;
    localparam int SLOT_IDX_W      = $clog2(NUM_ENEMIES_DEF);
    localparam int COORD_W         = 11;

    typedef logic [SLOT_IDX_W-1:0] slot_idx_t;
    typedef logic [COORD_W-1:0]    coord_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVE   = 2'd1,
        S_BOUNCE = 2'd2
    } swarm_state_t;

    // Unsigned add that clamps at the largest coordinate instead of wrapping
    function automatic coord_t sat_add(input coord_t a, input coord_t b);
        logic [COORD_W:0] w_sum;
        w_sum = {1'b0, a} + {1'b0, b};
        return w_sum[COORD_W] ? {COORD_W{1'b1}} : w_sum[COORD_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/enemy_hit_select.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_hit_select
//  Description : Combinational priority select of the enemy rectangle that
//                covers the current pixel. Lowest slot index wins.
//  Ports       : i_pixel_x/y   current pixel
//                i_alive       per-slot alive flags
//                i_pos_x/y     per-slot top-left positions
//                o_hit         pixel is inside some alive enemy
//                o_idx         selected slot (0 when no hit)
//                o_offset_x/y  pixel minus selected position (0 when no hit)
//  Revision    : 1.0 - initial release
// ============================================================================
module enemy_hit_select #(
    parameter int NUM_ENEMIES     = 4,
    parameter int OBJECT_WIDTH_X  = enemy_pkg::OBJECT_WIDTH_X,
    parameter int OBJECT_HEIGHT_Y = enemy_pkg::OBJECT_HEIGHT_Y
) (
    input  logic [10:0]                      i_pixel_x,
    input  logic [10:0]                      i_pixel_y,
    input  logic [NUM_ENEMIES-1:0]           i_alive,
    input  logic [NUM_ENEMIES-1:0][10:0]     i_pos_x,
    input  logic [NUM_ENEMIES-1:0][10:0]     i_pos_y,
    output logic                             o_hit,
    output logic [$clog2(NUM_ENEMIES)-1:0]   o_idx,
    output logic [10:0]                      o_offset_x,
    output logic [10:0]                      o_offset_y
);
    import enemy_pkg::*;

    localparam int          c_IDX_W = $clog2(NUM_ENEMIES);
    localparam logic [10:0] c_W     = 11'(OBJECT_WIDTH_X);
    localparam logic [10:0] c_H     = 11'(OBJECT_HEIGHT_Y);

    logic [NUM_ENEMIES-1:0]       w_hit;
    logic [NUM_ENEMIES-1:0][10:0] w_dx;
    logic [NUM_ENEMIES-1:0][10:0] w_dy;

    // 11-bit wrapping subtraction: a pixel left of / above the sprite wraps
    // to a large value and fails the "< size" test.
    for (genvar gi = 0; gi < NUM_ENEMIES; gi++) begin : g_slot
        assign w_dx[gi]  = i_pixel_x - i_pos_x[gi];
        assign w_dy[gi]  = i_pixel_y - i_pos_y[gi];
        assign w_hit[gi] = i_alive[gi] && (w_dx[gi] < c_W) && (w_dy[gi] < c_H);
    end

    // Scan from the top index down so the lowest hitting index is kept last
    always_comb begin
        o_hit      = 1'b0;
        o_idx      = '0;
        o_offset_x = '0;
        o_offset_y = '0;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                o_hit      = 1'b1;
                o_idx      = c_IDX_W'(i);
                o_offset_x = w_dx[i];
                o_offset_y = w_dy[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/enemy_swarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_swarm_ctrl
//  Description : Owns NUM_ENEMIES enemy slots sharing one bitmap ROM. Keeps
//                alive flags and positions, moves the swarm once per frame
//                (bouncing off the screen edges), services spawn/kill and
//                selects the enemy covering the current pixel.
//  Ports       : clk, resetN (async, active-low)
//                startOfFrame  frame pulse
//                pixelX/Y      current pixel
//                spawnReq/X/Y  spawn request -> spawnAck / spawnNack pulses
//                killReq/Idx   kill pulse
//                aliveMask, swarmEmpty
//                offsetX/Y, insideRectangle, enemyIdx  (1-cycle registered)
//                flip          common animation phase
//  Revision    : 1.0 - initial release
// ============================================================================
module enemy_swarm_ctrl #(
    parameter int NUM_ENEMIES     = 4,
    parameter int OBJECT_WIDTH_X  = enemy_pkg::OBJECT_WIDTH_X,
    parameter int OBJECT_HEIGHT_Y = enemy_pkg::OBJECT_HEIGHT_Y,
    parameter int STEP_X          = 2,
    parameter int STEP_Y          = 8,
    parameter int X_MAX           = 628,
    parameter int FLIP_TIME       = 5
) (
    input  logic                             clk,
    input  logic                             resetN,
    input  logic                             startOfFrame,
    input  logic [10:0]                      pixelX,
    input  logic [10:0]                      pixelY,
    input  logic                             spawnReq,
    input  logic [10:0]                      spawnX,
    input  logic [10:0]                      spawnY,
    output logic                             spawnAck,
    output logic                             spawnNack,
    input  logic                             killReq,
    input  logic [$clog2(NUM_ENEMIES)-1:0]   killIdx,
    output logic [NUM_ENEMIES-1:0]           aliveMask,
    output logic                             swarmEmpty,
    output logic [10:0]                      offsetX,
    output logic [10:0]                      offsetY,
    output logic                             insideRectangle,
    output logic [$clog2(NUM_ENEMIES)-1:0]   enemyIdx,
    output logic                             flip
);
    import enemy_pkg::*;

    localparam int                 c_IDX_W   = $clog2(NUM_ENEMIES);
    localparam int                 c_CNT_W   = (FLIP_TIME > 0) ? $clog2(FLIP_TIME + 1) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST    = c_IDX_W'(NUM_ENEMIES - 1);
    localparam logic [11:0]        c_X_MAX12 = 12'(X_MAX);
    localparam logic [11:0]        c_STEP_X12 = 12'(STEP_X);
    localparam logic [10:0]        c_STEP_X  = 11'(STEP_X);
    localparam logic [10:0]        c_STEP_Y  = 11'(STEP_Y);
    localparam logic [10:0]        c_X_MAX   = 11'(X_MAX);

    swarm_state_t                 r_state;
    logic [c_IDX_W-1:0]           r_slot;
    logic [NUM_ENEMIES-1:0]       r_alive;
    coord_t [NUM_ENEMIES-1:0]     r_x;
    coord_t [NUM_ENEMIES-1:0]     r_y;
    logic                         r_dir;        // 1 = moving right
    logic                         r_hit_edge;
    logic [c_CNT_W-1:0]           r_cnt;
    logic                         r_flip;
    logic                         r_spawn_ack;
    logic                         r_spawn_nack;
    logic [10:0]                  r_offset_x;
    logic [10:0]                  r_offset_y;
    logic                         r_inside;
    logic [c_IDX_W-1:0]           r_idx;

    // Lowest-index free slot, from the mask as it stood before any kill
    logic               w_free_found;
    logic [c_IDX_W-1:0] w_free_idx;
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
            if (!r_alive[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = c_IDX_W'(i);
            end
        end
    end

    // Horizontal move of the slot being processed, with edge clamping
    coord_t      w_cur_x;
    logic [11:0] w_sum_x;
    logic        w_edge;
    coord_t      w_move_x;
    always_comb begin
        w_cur_x = r_x[r_slot];
        w_sum_x = {1'b0, w_cur_x} + c_STEP_X12;
        if (r_dir) begin
            w_edge   = w_sum_x > c_X_MAX12;
            w_move_x = w_edge ? c_X_MAX : w_sum_x[10:0];
        end else begin
            w_edge   = w_cur_x < c_STEP_X;
            w_move_x = w_edge ? 11'd0 : (w_cur_x - c_STEP_X);
        end
    end

    logic w_move_edge;
    logic w_spawn_eval;
    assign w_move_edge  = r_alive[r_slot] && w_edge;
    // The cycle carrying an ack/nack is skipped so a held request gets a gap
    assign w_spawn_eval = (r_state == S_IDLE) && spawnReq && !r_spawn_ack && !r_spawn_nack;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= S_IDLE;
            r_slot       <= '0;
            r_alive      <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_dir        <= 1'b1;
            r_hit_edge   <= 1'b0;
            r_cnt        <= c_CNT_W'(FLIP_TIME);
            r_flip       <= 1'b0;
            r_spawn_ack  <= 1'b0;
            r_spawn_nack <= 1'b0;
        end else begin
            r_spawn_ack  <= 1'b0;
            r_spawn_nack <= 1'b0;

            // Animation counter runs on every frame pulse, whatever the FSM does
            if (startOfFrame) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end else begin
                    r_cnt  <= c_CNT_W'(FLIP_TIME);
                    r_flip <= ~r_flip;
                end
            end

            // A killed slot is alive, hence never the free slot chosen below
            if (killReq) begin
                r_alive[killIdx] <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_slot <= '0;
                    if (w_spawn_eval) begin
                        if (w_free_found) begin
                            r_alive[w_free_idx] <= 1'b1;
                            r_x[w_free_idx]     <= spawnX;
                            r_y[w_free_idx]     <= spawnY;
                            r_spawn_ack         <= 1'b1;
                        end else begin
                            r_spawn_nack <= 1'b1;
                        end
                    end
                    if (startOfFrame) begin
                        r_state <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (r_alive[r_slot]) begin
                        r_x[r_slot] <= w_move_x;
                    end
                    if (w_move_edge) begin
                        r_hit_edge <= 1'b1;
                    end
                    if (r_slot == c_LAST) begin
                        r_state <= (r_hit_edge || w_move_edge) ? S_BOUNCE : S_IDLE;
                    end
                    r_slot <= r_slot + c_IDX_W'(1);
                end
                S_BOUNCE: begin
                    r_dir <= ~r_dir;
                    for (int i = 0; i < NUM_ENEMIES; i++) begin
                        if (r_alive[i]) begin
                            r_y[i] <= sat_add(r_y[i], c_STEP_Y);
                        end
                    end
                    r_hit_edge <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Pixel path: combinational select, one register stage here
    logic               w_sel_hit;
    logic [c_IDX_W-1:0] w_sel_idx;
    logic [10:0]        w_sel_off_x;
    logic [10:0]        w_sel_off_y;

    enemy_hit_select #(
        .NUM_ENEMIES     (NUM_ENEMIES),
        .OBJECT_WIDTH_X  (OBJECT_WIDTH_X),
        .OBJECT_HEIGHT_Y (OBJECT_HEIGHT_Y)
    ) u_hit_select (
        .i_pixel_x  (pixelX),
        .i_pixel_y  (pixelY),
        .i_alive    (r_alive),
        .i_pos_x    (r_x),
        .i_pos_y    (r_y),
        .o_hit      (w_sel_hit),
        .o_idx      (w_sel_idx),
        .o_offset_x (w_sel_off_x),
        .o_offset_y (w_sel_off_y)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_inside   <= 1'b0;
            r_idx      <= '0;
            r_offset_x <= '0;
            r_offset_y <= '0;
        end else begin
            r_inside   <= w_sel_hit;
            r_idx      <= w_sel_idx;
            r_offset_x <= w_sel_off_x;
            r_offset_y <= w_sel_off_y;
        end
    end

    assign spawnAck        = r_spawn_ack;
    assign spawnNack       = r_spawn_nack;
    assign aliveMask       = r_alive;
    assign swarmEmpty      = ~|r_alive;
    assign offsetX         = r_offset_x;
    assign offsetY         = r_offset_y;
    assign insideRectangle = r_inside;
    assign enemyIdx        = r_idx;
    assign flip            = r_flip;

endmodule
`default_nettype wire

// File: tb/tb_enemy_swarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enemy_swarm_ctrl
//  Description : Self-checking bench for enemy_swarm_ctrl. Directed scenarios
//                followed by random spawn/kill/frame/probe operations, all
//                checked against a slot-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_swarm_ctrl;
    import enemy_pkg::*;

    localparam int N         = 4;
    localparam int W         = 11;
    localparam int H         = 48;
    localparam int STEP_X    = 2;
    localparam int STEP_Y    = 8;
    localparam int X_MAX     = 628;
    localparam int FLIP_TIME = 5;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [10:0] pixelX, pixelY;
    logic        spawnReq;
    logic [10:0] spawnX, spawnY;
    logic        spawnAck, spawnNack;
    logic        killReq;
    slot_idx_t   killIdx;
    logic [N-1:0] aliveMask;
    logic        swarmEmpty;
    logic [10:0] offsetX, offsetY;
    logic        insideRectangle;
    slot_idx_t   enemyIdx;
    logic        flip;

    always #5 clk = ~clk;

    enemy_swarm_ctrl #(
        .NUM_ENEMIES(N), .OBJECT_WIDTH_X(W), .OBJECT_HEIGHT_Y(H),
        .STEP_X(STEP_X), .STEP_Y(STEP_Y), .X_MAX(X_MAX), .FLIP_TIME(FLIP_TIME)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY),
        .spawnReq(spawnReq), .spawnX(spawnX), .spawnY(spawnY),
        .spawnAck(spawnAck), .spawnNack(spawnNack),
        .killReq(killReq), .killIdx(killIdx),
        .aliveMask(aliveMask), .swarmEmpty(swarmEmpty),
        .offsetX(offsetX), .offsetY(offsetY),
        .insideRectangle(insideRectangle), .enemyIdx(enemyIdx), .flip(flip)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: slot list, direction, frames since reset
    bit m_alive [N];
    int m_x     [N];
    int m_y     [N];
    bit m_dir;
    int m_frames;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_alive[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
        end
        m_dir    = 1'b1;
        m_frames = 0;
    endtask

    task automatic reset_dut();
        resetN = 1'b0;
        repeat (2) step();
        resetN = 1'b1;
        step();
        model_reset();
    endtask

    task automatic check_status(input string tag);
        logic [N-1:0] mk;
        mk = '0;
        for (int i = 0; i < N; i++) mk[i] = m_alive[i];
        chk({tag, ".mask"},  32'(aliveMask),  32'(mk));
        chk({tag, ".empty"}, 32'(swarmEmpty), 32'(mk == '0));
        // flip toggles every FLIP_TIME+1 frames, starting low
        chk({tag, ".flip"},  32'(flip), 32'((m_frames / (FLIP_TIME + 1)) % 2));
    endtask

    task automatic spawn(input int x, input int y, input string tag);
        int slot;
        slot = -1;
        for (int i = 0; i < N; i++) if (slot < 0 && !m_alive[i]) slot = i;
        spawnX = 11'(x); spawnY = 11'(y); spawnReq = 1'b1;
        step();
        chk({tag, ".ack"},  32'(spawnAck),  32'(slot >= 0));
        chk({tag, ".nack"}, 32'(spawnNack), 32'(slot < 0));
        spawnReq = 1'b0;
        if (slot >= 0) begin
            m_alive[slot] = 1'b1; m_x[slot] = x; m_y[slot] = y;
        end
        step();
        chk({tag, ".pulse"}, 32'({spawnAck, spawnNack}), 32'(0));
    endtask

    task automatic kill(input int k);
        killIdx = slot_idx_t'(k); killReq = 1'b1;
        step();
        killReq = 1'b0;
        m_alive[k] = 1'b0;
    endtask

    // Whole-frame effect: every live enemy steps; any wall contact reverses
    // the swarm and drops everyone by STEP_Y.
    task automatic model_frame();
        bit wall;
        wall = 1'b0;
        m_frames++;
        for (int i = 0; i < N; i++) begin
            if (m_alive[i]) begin
                if (m_dir) begin
                    if (m_x[i] + STEP_X > X_MAX) begin m_x[i] = X_MAX; wall = 1'b1; end
                    else m_x[i] = m_x[i] + STEP_X;
                end else begin
                    if (m_x[i] < STEP_X) begin m_x[i] = 0; wall = 1'b1; end
                    else m_x[i] = m_x[i] - STEP_X;
                end
            end
        end
        if (wall) begin
            m_dir = !m_dir;
            for (int i = 0; i < N; i++)
                if (m_alive[i]) m_y[i] = (m_y[i] + STEP_Y > 2047) ? 2047 : m_y[i] + STEP_Y;
        end
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        repeat (N + 2) step();
        model_frame();
    endtask

    task automatic probe(input int px, input int py, input string tag);
        bit h; int idx, ox, oy;
        h = 1'b0; idx = 0; ox = 0; oy = 0;
        for (int i = 0; i < N; i++) begin
            if (!h && m_alive[i] && px >= m_x[i] && px < m_x[i] + W
                               && py >= m_y[i] && py < m_y[i] + H) begin
                h = 1'b1; idx = i; ox = px - m_x[i]; oy = py - m_y[i];
            end
        end
        pixelX = 11'(px); pixelY = 11'(py);
        step();
        chk({tag, ".inside"}, 32'(insideRectangle), 32'(h));
        chk({tag, ".idx"},    32'(enemyIdx),        32'(idx));
        chk({tag, ".offx"},   32'(offsetX),         32'(ox));
        chk({tag, ".offy"},   32'(offsetY),         32'(oy));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; pixelX = '0; pixelY = '0;
        spawnReq = 1'b0; spawnX = '0; spawnY = '0; killReq = 1'b0; killIdx = '0;
        model_reset();

        // Reset state
        reset_dut();
        check_status("reset");
        chk("reset.inside", 32'(insideRectangle), 32'(0));
        chk("reset.idx",    32'(enemyIdx),        32'(0));
        chk("reset.offs",   32'({offsetX, offsetY}), 32'(0));
        chk("reset.ack",    32'({spawnAck, spawnNack}), 32'(0));

        // First spawn and pixel lookup
        spawn(100, 50, "sp0");
        check_status("sp0");
        probe(105, 60, "px0");
        probe(99, 60, "px_left");
        probe(105, 49, "px_above");
        probe(110, 97, "px_corner");
        probe(111, 60, "px_right");

        // Fill all slots, then one more gets refused
        spawn(300, 200, "sp1");
        spawn(305, 210, "sp2");
        spawn(400, 300, "sp3");
        spawn(50, 50, "sp_full");
        check_status("full");

        // Overlap priority, then kill the winner
        probe(306, 215, "ovl");
        kill(1);
        probe(306, 215, "ovl_kill");
        check_status("kill1");
        spawn(300, 200, "respawn1");
        check_status("refill");

        // Kill and spawn together: kill lands, spawn still sees a full swarm
        killIdx = slot_idx_t'(0); killReq = 1'b1;
        spawnX = 11'(10); spawnY = 11'(10); spawnReq = 1'b1;
        step();
        killReq = 1'b0;
        m_alive[0] = 1'b0;
        chk("ks.nack", 32'(spawnNack), 32'(1));
        chk("ks.ack",  32'(spawnAck),  32'(0));
        spawnReq = 1'b0;
        step();
        check_status("ks");
        spawn(120, 60, "ks_next");
        probe(121, 61, "ks_probe");

        // Six frames: flip toggles on the sixth
        for (int f = 0; f < 6; f++) begin
            frame();
            check_status("flipfr");
            for (int i = 0; i < N; i++) probe(m_x[i], m_y[i], "flip_slot");
        end

        // Right-edge bounce then move left
        reset_dut();
        spawn(627, 100, "edge_sp");
        frame();
        probe(628, 108, "edge_clamp");
        probe(627, 108, "edge_left");
        frame();
        probe(626, 108, "edge_back");

        // Random operations
        reset_dut();
        for (int it = 0; it < 80; it++) begin
            int op, k, px, py;
            op = int'($urandom_range(0, 3));
            case (op)
                0: spawn(int'($urandom_range(0, X_MAX)), int'($urandom_range(0, 300)), "rnd_sp");
                1: kill(int'($urandom_range(0, N - 1)));
                2: frame();
                default: probe(int'($urandom_range(0, 700)), int'($urandom_range(0, 500)), "rnd_px");
            endcase
            check_status("rnd");
            k  = int'($urandom_range(0, N - 1));
            px = m_x[k] + int'($urandom_range(0, W + 3)) - 2;
            py = m_y[k] + int'($urandom_range(0, H + 3)) - 2;
            if (px < 0) px = 0;
            if (py < 0) py = 0;
            probe(px, py, "rnd_near");
        end

        // Reset asserted in the middle of MOVE
        reset_dut();
        spawn(200, 100, "rm_sp0");
        spawn(250, 120, "rm_sp1");
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        step();
        #2 resetN = 1'b0;
        #1;
        model_reset();
        check_status("rst_mid");
        @(posedge clk); #1;
        resetN = 1'b1;
        step();
        spawn(10, 10, "rm_after");
        check_status("rm_after");
        probe(10, 10, "rm_probe");

        // Vertical saturation at the bottom
        reset_dut();
        spawn(627, 2045, "sat_sp");
        frame();
        probe(628, 2047, "sat_px");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
